i2c_line_filter: RTL and testbench

Input conditioning stage for the APB I2C master's SCL and SDA pins. It synchronises each raw open-drain input into the `clk` domain and applies a programmable stable-count glitch filter. It drives clean, registered line levels directly into the edge detectors and START/STOP logic downstream, and reports rejected glitches for status/debug.

---
 rtl/i2c_line_filter.sv | 91 +++++++++
 tb/tb_i2c_line_filter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_line_filter.sv
// SCL/SDA input conditioning: per-line synchroniser followed by a programmable
// stable-count glitch filter with registered line levels and glitch pulses.
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scl_in,
  input  logic                 sda_in,
  input  logic                 filter_en,
  input  logic [CNT_WIDTH-1:0] filter_len,
  output logic                 scl_filt,
  output logic                 sda_filt,
  output logic                 scl_glitch,
  output logic                 sda_glitch
);

  localparam int NUM_LINES = 2;  // index 0 = SCL, index 1 = SDA

  typedef logic [CNT_WIDTH-1:0]   cnt_t;
  typedef logic [SYNC_STAGES-1:0] sync_t;

  logic [NUM_LINES-1:0] pin;
  logic [NUM_LINES-1:0] sync_last;
  sync_t                sync_q   [NUM_LINES];
  sync_t                sync_d   [NUM_LINES];
  cnt_t                 cnt_q    [NUM_LINES];
  cnt_t                 cnt_d    [NUM_LINES];
  logic [NUM_LINES-1:0] filt_q,   filt_d;
  logic [NUM_LINES-1:0] glitch_q, glitch_d;
  cnt_t                 len_m1;

  assign pin = {sda_in, scl_in};

  // A zero length behaves as one: accept on the first differing cycle.
  assign len_m1 = (filter_len == '0) ? '0 : filter_len - cnt_t'(1);

  // NOTE: every variable gets its default before any branch so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_LINES; i++) begin
      sync_d[i]    = {sync_q[i][SYNC_STAGES-2:0], pin[i]};
      sync_last[i] = sync_q[i][SYNC_STAGES-1];
      filt_d[i]    = filt_q[i];
      cnt_d[i]     = cnt_q[i];
      glitch_d[i]  = 1'b0;

      if (!filter_en) begin
        filt_d[i] = sync_last[i];
        cnt_d[i]  = '0;
      end else if (sync_last[i] != filt_q[i]) begin
        // >= lets a mid-count drop of filter_len accept the pending level at once.
        if (cnt_q[i] >= len_m1) begin
          filt_d[i] = sync_last[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + cnt_t'(1);
        end
      end else if (cnt_q[i] != '0) begin
        cnt_d[i]    = '0;
        glitch_d[i] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the synchroniser
  // is reset to the idle-high bus level so no false edge follows reset release.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        sync_q[i] <= '1;
        cnt_q[i]  <= '0;
      end
      filt_q   <= '1;
      glitch_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LINES; i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      filt_q   <= filt_d;
      glitch_q <= glitch_d;
    end
  end

  assign scl_filt   = filt_q[0];
  assign sda_filt   = filt_q[1];
  assign scl_glitch = glitch_q[0];
  assign sda_glitch = glitch_q[1];

endmodule

// File: tb/tb_i2c_line_filter.sv
// Self-checking bench for i2c_line_filter: directed scenarios plus random pin
// activity, all compared against a run-length reference model.
`timescale 1ns/1ps
module tb_i2c_line_filter;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_WIDTH   = 8;

  logic                 clk        = 1'b0;
  logic                 reset      = 1'b1;
  logic                 scl_in     = 1'b1;
  logic                 sda_in     = 1'b1;
  logic                 filter_en  = 1'b1;
  logic [CNT_WIDTH-1:0] filter_len = 8'd3;
  logic                 scl_filt, sda_filt, scl_glitch, sda_glitch;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  i2c_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .filter_en (filter_en),
    .filter_len(filter_len),
    .scl_filt  (scl_filt),
    .sda_filt  (sda_filt),
    .scl_glitch(scl_glitch),
    .sda_glitch(sda_glitch)
  );

  // Reference model: the synchroniser is a plain delay queue of pin samples;
  // a new level is accepted once it has been seen for L_eff consecutive cycles.
  bit [1:0] m_pins [$];
  bit       m_filt   [2];
  bit       m_glitch [2];
  int       m_run    [2];

  always @(posedge clk) begin
    bit [1:0] s;
    bit [1:0] now;
    int       leff;
    now = {sda_in, scl_in};
    if (reset) begin
      m_pins.delete();
      repeat (SYNC_STAGES) m_pins.push_back(2'b11);
      for (int i = 0; i < 2; i++) begin
        m_filt[i]   = 1'b1;
        m_glitch[i] = 1'b0;
        m_run[i]    = 0;
      end
    end else begin
      s    = m_pins[0];
      leff = (filter_len == 0) ? 1 : int'(filter_len);
      for (int i = 0; i < 2; i++) begin
        m_glitch[i] = 1'b0;
        if (!filter_en) begin
          m_filt[i] = s[i];
          m_run[i]  = 0;
        end else if (s[i] != m_filt[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= leff) begin
            m_filt[i] = s[i];
            m_run[i]  = 0;
          end
        end else begin
          m_glitch[i] = (m_run[i] != 0);
          m_run[i]    = 0;
        end
      end
      void'(m_pins.pop_front());
      m_pins.push_back(now);
    end
  end

  logic [3:0] obs, mdl;
  assign obs = {scl_filt, sda_filt, scl_glitch, sda_glitch};
  assign mdl = {m_filt[0], m_filt[1], m_glitch[0], m_glitch[1]};

  function automatic logic [CNT_WIDTH-1:0] to_len(input int v);
    return CNT_WIDTH'(v);
  endfunction

  task automatic test_reset();
    int fall = -1;
    scl_in = 1'b0; sda_in = 1'b0; filter_en = 1'b1; filter_len = to_len(3); reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (obs !== 4'b1100) begin n_fail++; $display("FAIL reset_hold: got %b expected 1100", obs); end
    end
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== mdl) begin n_fail++; $display("FAIL reset_model k=%0d: got %b expected %b", k, obs, mdl); end
      if (k == 1) begin
        n_tests++;
        if (obs !== 4'b1100) begin n_fail++; $display("FAIL reset_first_cycle: got %b expected 1100", obs); end
      end
      if (fall < 0 && scl_filt === 1'b0 && sda_filt === 1'b0) fall = k;
    end
    n_tests++;
    if (fall != 5) begin n_fail++; $display("FAIL reset_fall_edge: got %0d expected 5", fall); end
  endtask

  task automatic test_latency();
    int fall = -1, glitches = 0, scl_bad = 0;
    scl_in = 1'b1; sda_in = 1'b1; filter_len = to_len(3);
    repeat (8) begin
      @(negedge clk);
      n_tests++;
      if (obs !== mdl) begin n_fail++; $display("FAIL latency_settle: got %b expected %b", obs, mdl); end
    end
    sda_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== mdl) begin n_fail++; $display("FAIL latency_model k=%0d: got %b expected %b", k, obs, mdl); end
      if (fall < 0 && sda_filt === 1'b0) fall = k;
      if (sda_glitch !== 1'b0) glitches++;
      if (scl_filt !== 1'b1) scl_bad++;
    end
    n_tests++;
    if (fall != 5) begin n_fail++; $display("FAIL latency_edge: got %0d expected 5", fall); end
    n_tests++;
    if (glitches != 0) begin n_fail++; $display("FAIL latency_glitch: got %0d expected 0", glitches); end
    n_tests++;
    if (scl_bad != 0) begin n_fail++; $display("FAIL latency_scl_disturbed: got %0d expected 0", scl_bad); end
  endtask

  task automatic test_glitch_reject();
    int glitches = 0, lows = 0, fall = -1;
    sda_in = 1'b1; filter_len = to_len(4);
    repeat (10) begin
      @(negedge clk);
      n_tests++;
      if (obs !== mdl) begin n_fail++; $display("FAIL glitch_settle: got %b expected %b", obs, mdl); end
    end
    scl_in = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== mdl) begin n_fail++; $display("FAIL glitch3_model k=%0d: got %b expected %b", k, obs, mdl); end
      if (scl_glitch === 1'b1) glitches++;
      if (scl_filt !== 1'b1) lows++;
      if (k == 3) scl_in = 1'b1;
    end
    n_tests++;
    if (glitches != 1) begin n_fail++; $display("FAIL glitch3_pulses: got %0d expected 1", glitches); end
    n_tests++;
    if (lows != 0) begin n_fail++; $display("FAIL glitch3_passed: got %0d low cycles expected 0", lows); end
    glitches = 0; lows = 0;
    scl_in = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== mdl) begin n_fail++; $display("FAIL pulse4_model k=%0d: got %b expected %b", k, obs, mdl); end
      if (scl_glitch === 1'b1) glitches++;
      if (scl_filt === 1'b0) lows++;
      if (fall < 0 && scl_filt === 1'b0) fall = k;
      if (k == 4) scl_in = 1'b1;
    end
    n_tests++;
    if (fall != 6) begin n_fail++; $display("FAIL pulse4_delay: got %0d expected 6", fall); end
    n_tests++;
    if (lows != 4) begin n_fail++; $display("FAIL pulse4_width: got %0d expected 4", lows); end
    n_tests++;
    if (glitches != 0) begin n_fail++; $display("FAIL pulse4_glitch: got %0d expected 0", glitches); end
  endtask

  task automatic test_boundary_len();
    int fall, lows, glitches;
    int lens [2] = '{0, 1};
    foreach (lens[j]) begin
      filter_len = to_len(lens[j]);
      scl_in = 1'b1;
      repeat (6) @(negedge clk);
      fall = -1;
      scl_in = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        n_tests++;
        if (obs !== mdl) begin n_fail++; $display("FAIL len%0d_model k=%0d: got %b expected %b", lens[j], k, obs, mdl); end
        if (fall < 0 && scl_filt === 1'b0) fall = k;
      end
      n_tests++;
      if (fall != 3) begin n_fail++; $display("FAIL len%0d_latency: got %0d expected 3", lens[j], fall); end
      scl_in = 1'b1;
      repeat (6) @(negedge clk);
      lows = 0; glitches = 0;
      scl_in = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        n_tests++;
        if (obs !== mdl) begin n_fail++; $display("FAIL len%0d_pulse_model k=%0d: got %b expected %b", lens[j], k, obs, mdl); end
        if (scl_filt === 1'b0) lows++;
        if (scl_glitch === 1'b1) glitches++;
        if (k == 1) scl_in = 1'b1;
      end
      n_tests++;
      if (lows != 1 || glitches != 0) begin
        n_fail++; $display("FAIL len%0d_pulse1: got lows=%0d glitches=%0d expected lows=1 glitches=0", lens[j], lows, glitches);
      end
    end
    filter_len = to_len(255);
    fall = -1;
    sda_in = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== mdl) begin n_fail++; $display("FAIL len255_model k=%0d: got %b expected %b", k, obs, mdl); end
      if (fall < 0 && sda_filt === 1'b0) fall = k;
    end
    n_tests++;
    if (fall != 257) begin n_fail++; $display("FAIL len255_latency: got %0d expected 257", fall); end
    sda_in = 1'b1;
    repeat (300) @(negedge clk);
    lows = 0; glitches = 0;
    sda_in = 1'b0;
    for (int k = 1; k <= 280; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== mdl) begin n_fail++; $display("FAIL len255_pulse_model k=%0d: got %b expected %b", k, obs, mdl); end
      if (sda_filt === 1'b0) lows++;
      if (sda_glitch === 1'b1) glitches++;
      if (k == 254) sda_in = 1'b1;
    end
    n_tests++;
    if (lows != 0 || glitches != 1) begin
      n_fail++; $display("FAIL len255_pulse254: got lows=%0d glitches=%0d expected lows=0 glitches=1", lows, glitches);
    end
  endtask

  task automatic test_mode_change();
    int glitches = 0, fall = -1;
    filter_len = to_len(10);
    repeat (15) @(negedge clk);
    scl_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== mdl) begin n_fail++; $display("FAIL lendrop_model k=%0d: got %b expected %b", k, obs, mdl); end
      if (k == 7) begin
        n_tests++;
        if (scl_filt !== 1'b1) begin n_fail++; $display("FAIL lendrop_early: got %b expected 1", scl_filt); end
        filter_len = to_len(2);
      end
      if (k == 8) begin
        n_tests++;
        if (scl_filt !== 1'b0) begin n_fail++; $display("FAIL lendrop_accept: got %b expected 0", scl_filt); end
      end
    end
    scl_in = 1'b1;
    filter_len = to_len(10);
    repeat (15) @(negedge clk);
    sda_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== mdl) begin n_fail++; $display("FAIL bypass_switch_model k=%0d: got %b expected %b", k, obs, mdl); end
      if (sda_glitch === 1'b1) glitches++;
      if (k == 5) begin
        n_tests++;
        if (sda_filt !== 1'b1) begin n_fail++; $display("FAIL bypass_switch_early: got %b expected 1", sda_filt); end
        filter_en = 1'b0;
      end
      if (k == 6) begin
        n_tests++;
        if (sda_filt !== 1'b0) begin n_fail++; $display("FAIL bypass_switch_follow: got %b expected 0", sda_filt); end
      end
    end
    n_tests++;
    if (glitches != 0) begin n_fail++; $display("FAIL bypass_switch_glitch: got %0d expected 0", glitches); end
    scl_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== mdl) begin n_fail++; $display("FAIL bypass_model k=%0d: got %b expected %b", k, obs, mdl); end
      if (fall < 0 && scl_filt === 1'b0) fall = k;
    end
    n_tests++;
    if (fall != 3) begin n_fail++; $display("FAIL bypass_latency: got %0d expected 3", fall); end
    scl_in = 1'b1; sda_in = 1'b1; filter_en = 1'b1; filter_len = to_len(4);
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int glitches = 0, fall = -1;
    sda_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== mdl) begin n_fail++; $display("FAIL rstmid_model k=%0d: got %b expected %b", k, obs, mdl); end
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs !== 4'b1100) begin n_fail++; $display("FAIL rstmid_state: got %b expected 1100", obs); end
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== mdl) begin n_fail++; $display("FAIL rstmid_after k=%0d: got %b expected %b", k, obs, mdl); end
      if (sda_glitch === 1'b1) glitches++;
      if (fall < 0 && sda_filt === 1'b0) fall = k;
    end
    n_tests++;
    if (fall != 6) begin n_fail++; $display("FAIL rstmid_latency: got %0d expected 6", fall); end
    n_tests++;
    if (glitches != 0) begin n_fail++; $display("FAIL rstmid_glitch: got %0d expected 0", glitches); end
  endtask

  task automatic test_random();
    int hold [2] = '{1, 1};
    int shown = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== mdl) begin
        n_fail++;
        if (shown < 20) $display("FAIL random_model k=%0d: got %b expected %b", k, obs, mdl);
        shown++;
      end
      if (k % 250 == 0) filter_len = to_len(int'($urandom_range(0, 5)));
      if (k % 100 == 0) filter_en = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) begin
        hold[i] = hold[i] - 1;
        if (hold[i] == 0) begin
          if (i == 0) scl_in = ~scl_in; else sda_in = ~sda_in;
          hold[i] = int'($urandom_range(1, 8));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch_reject();
    test_boundary_len();
    test_mode_change();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
